// File: rtl/sigmoid_lut_arbiter.sv
// Round-robin sharing of one synchronous-read sigmoid LUT among NUM_REQ neuron
// requesters, with per-requester result registers and valid/ready responses.
module sigmoid_lut_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int IN_W       = 16,
  parameter int FRAC_SHIFT = 6,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 10
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        io_req_valid,
  input  logic [NUM_REQ*IN_W-1:0]   io_req_x,
  output logic [NUM_REQ-1:0]        io_req_ready,
  output logic [NUM_REQ-1:0]        io_resp_valid,
  input  logic [NUM_REQ-1:0]        io_resp_ready,
  output logic [NUM_REQ*DATA_W-1:0] io_resp_data,
  output logic [ADDR_W-1:0]         io_lutAddr,
  input  logic [DATA_W-1:0]         io_lutData,
  output logic                      io_busy
);

  localparam int TAG_W = $clog2(NUM_REQ);
  localparam logic signed [IN_W-1:0] S_MAX = IN_W'(2**(ADDR_W-1) - 1);
  localparam logic signed [IN_W-1:0] S_MIN = IN_W'(-(2**(ADDR_W-1)));

  logic [NUM_REQ-1:0] pend;
  logic [TAG_W-1:0]   last_grant;
  logic [TAG_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               s1_valid, s2_valid;
  logic [TAG_W-1:0]   s1_tag, s2_tag;

  logic signed [IN_W-1:0] sel_x;
  logic signed [IN_W-1:0] shifted;
  logic [ADDR_W-1:0]      lut_addr;

  // Pending requesters are masked out, so a result slot is always free on return.
  always_comb begin
    logic [TAG_W-1:0] cand;
    io_req_ready = '0;
    gnt_any      = 1'b0;
    gnt_idx      = '0;
    cand         = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = TAG_W'((32'(last_grant) + k) % NUM_REQ);
      if (!gnt_any && io_req_valid[cand] && !pend[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) io_req_ready[gnt_idx] = 1'b1;
  end

  // Clamp to the signed ADDR_W range, then offset by flipping the MSB.
  always_comb begin
    sel_x   = io_req_x[gnt_idx*IN_W +: IN_W];
    shifted = sel_x >>> FRAC_SHIFT;
    if (shifted > S_MAX)      lut_addr = '1;
    else if (shifted < S_MIN) lut_addr = '0;
    else                      lut_addr = {~shifted[ADDR_W-1], shifted[ADDR_W-2:0]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend          <= '0;
      last_grant    <= TAG_W'(NUM_REQ - 1);
      s1_valid      <= 1'b0;
      s2_valid      <= 1'b0;
      s1_tag        <= '0;
      s2_tag        <= '0;
      io_lutAddr    <= '0;
      io_resp_valid <= '0;
      io_resp_data  <= '0;
    end else begin
      s1_valid <= gnt_any;
      s2_valid <= s1_valid;
      s2_tag   <= s1_tag;
      if (gnt_any) begin
        io_lutAddr <= lut_addr;
        s1_tag     <= gnt_idx;
        last_grant <= gnt_idx;
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (gnt_any && gnt_idx == TAG_W'(i))
          pend[i] <= 1'b1;
        else if (io_resp_valid[i] && io_resp_ready[i])
          pend[i] <= 1'b0;

        if (s2_valid && s2_tag == TAG_W'(i)) begin
          io_resp_valid[i]                 <= 1'b1;
          io_resp_data[i*DATA_W +: DATA_W] <= io_lutData;
        end else if (io_resp_valid[i] && io_resp_ready[i]) begin
          io_resp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign io_busy = |pend;

endmodule

// File: tb/tb_sigmoid_lut_arbiter.sv
// Directed bench for sigmoid_lut_arbiter: address mapping table, round-robin,
// backpressure and mid-operation reset sequences against a behavioural LUT.
module tb_sigmoid_lut_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  io_req_valid;
  logic [63:0] io_req_x;
  logic [3:0]  io_req_ready;
  logic [3:0]  io_resp_valid;
  logic [3:0]  io_resp_ready;
  logic [39:0] io_resp_data;
  logic [9:0]  io_lutAddr;
  logic [9:0]  io_lutData;
  logic        io_busy;

  int checks   = 0;
  int failures = 0;

  sigmoid_lut_arbiter #(
    .NUM_REQ(4), .IN_W(16), .FRAC_SHIFT(6), .ADDR_W(10), .DATA_W(10)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .io_req_valid(io_req_valid), .io_req_x(io_req_x), .io_req_ready(io_req_ready),
    .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
    .io_resp_data(io_resp_data), .io_lutAddr(io_lutAddr),
    .io_lutData(io_lutData), .io_busy(io_busy)
  );

  always #5 clock = ~clock;

  function automatic logic [9:0] lut_word(input logic [9:0] a);
    return a ^ 10'h2A5;
  endfunction

  // Synchronous-read LUT model: data for the address seen at an edge appears after it.
  always_ff @(posedge clock) io_lutData <= lut_word(io_lutAddr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    io_req_valid  = '0;
    io_resp_ready = 4'b1111;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0] x;
    int          req;
    logic [9:0]  addr;
  } vec_t;

  vec_t vecs[12];
  logic [3:0] gtab[15];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{16'h0000, 1, 10'd512};
    vecs[1]  = '{16'h7FFF, 0, 10'd1023};
    vecs[2]  = '{16'h8000, 2, 10'd0};
    vecs[3]  = '{16'hFFC0, 3, 10'd511};
    vecs[4]  = '{16'h0040, 0, 10'd513};
    vecs[5]  = '{16'h003F, 1, 10'd512};
    vecs[6]  = '{16'hFFFF, 2, 10'd511};
    vecs[7]  = '{16'h7FC0, 3, 10'd1023};
    vecs[8]  = '{16'h8040, 0, 10'd1};
    vecs[9]  = '{16'h1000, 1, 10'd576};
    vecs[10] = '{16'hE000, 2, 10'd384};
    vecs[11] = '{16'h8001, 3, 10'd0};
    // Expected grants with resp_ready[2] held low and all four requesting.
    gtab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0000, 4'b1000,
             4'b0001, 4'b0010, 4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0000};

    reset_n       = 1'b0;
    io_req_valid  = '0;
    io_req_x      = '0;
    io_resp_ready = 4'b1111;
    #2;
    chk("rst_resp_valid", 64'(io_resp_valid), 64'd0);
    chk("rst_resp_data",  64'(io_resp_data),  64'd0);
    chk("rst_lut_addr",   64'(io_lutAddr),    64'd0);
    chk("rst_busy",       64'(io_busy),       64'd0);
    chk("rst_req_ready",  64'(io_req_ready),  64'd0);
    do_reset();

    // Address mapping table; each entry is a full single-request transaction.
    for (int v = 0; v < 12; v++) begin
      int r;
      r = vecs[v].req;
      @(posedge clock); #1;
      io_req_valid[r]         = 1'b1;
      io_req_x[r*16 +: 16]    = vecs[v].x;
      @(negedge clock);
      chk("vec_req_ready", 64'(io_req_ready), 64'(4'b0001 << r));
      @(posedge clock); #1;
      io_req_valid = '0;
      @(negedge clock);
      chk("vec_lut_addr", 64'(io_lutAddr), 64'(vecs[v].addr));
      chk("vec_busy_t1",  64'(io_busy), 64'd1);
      @(negedge clock);
      chk("vec_busy_t2",  64'(io_busy), 64'd1);
      @(negedge clock);
      chk("vec_resp_valid", 64'(io_resp_valid), 64'(4'b0001 << r));
      chk("vec_resp_data",  64'(io_resp_data[r*10 +: 10]), 64'(lut_word(vecs[v].addr)));
      chk("vec_busy_t3",    64'(io_busy), 64'd1);
      @(negedge clock);
      chk("vec_resp_clear", 64'(io_resp_valid), 64'd0);
      chk("vec_busy_t4",    64'(io_busy), 64'd0);
    end

    // Round-robin with all requesters continuously valid.
    do_reset();
    for (int i = 0; i < 4; i++) io_req_x[i*16 +: 16] = 16'(i * 64);
    @(posedge clock); #1;
    io_req_valid = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      chk("rr_grant", 64'(io_req_ready), 64'(4'b0001 << (c % 4)));
      if (c >= 1) chk("rr_lut_addr", 64'(io_lutAddr), 64'(512 + (c - 1) % 4));
      if (c >= 3) begin
        chk("rr_resp_valid", 64'(io_resp_valid), 64'(4'b0001 << ((c - 3) % 4)));
        chk("rr_resp_data", 64'(io_resp_data[((c - 3) % 4)*10 +: 10]),
            64'(lut_word(10'(512 + (c - 3) % 4))));
      end
      @(posedge clock); #1;
    end
    io_req_valid = '0;
    repeat (6) @(posedge clock);

    // Backpressure on requester 2 for the response phase.
    do_reset();
    @(posedge clock); #1;
    io_req_valid  = 4'b1111;
    io_resp_ready = 4'b1011;
    for (int c = 0; c < 15; c++) begin
      @(negedge clock);
      chk("bp_grant", 64'(io_req_ready), 64'(gtab[c]));
      if (c >= 5) begin
        chk("bp_resp_valid2", 64'(io_resp_valid[2]), 64'd1);
        chk("bp_resp_data2",  64'(io_resp_data[20 +: 10]), 64'(lut_word(10'd514)));
      end
      @(posedge clock); #1;
    end
    io_resp_ready = 4'b1111;
    io_req_valid  = 4'b0100;
    @(negedge clock);
    chk("bp_hs_no_grant", 64'(io_req_ready), 64'd0);
    chk("bp_hs_valid2",   64'(io_resp_valid[2]), 64'd1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("bp_reaccept", 64'(io_req_ready), 64'(4'b0100));
    @(posedge clock); #1;
    io_req_valid = '0;
    repeat (6) @(posedge clock);

    // Reset asserted with lookups in flight.
    do_reset();
    @(posedge clock); #1;
    io_req_valid = 4'b1111;
    repeat (3) begin @(posedge clock); #1; end
    reset_n      = 1'b0;
    io_req_valid = '0;
    #1;
    chk("mid_rst_resp_valid", 64'(io_resp_valid), 64'd0);
    chk("mid_rst_resp_data",  64'(io_resp_data),  64'd0);
    chk("mid_rst_lut_addr",   64'(io_lutAddr),    64'd0);
    chk("mid_rst_busy",       64'(io_busy),       64'd0);
    @(posedge clock); #1;
    chk("mid_rst_hold_valid", 64'(io_resp_valid), 64'd0);
    chk("mid_rst_hold_addr",  64'(io_lutAddr),    64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk("post_rst_no_stale", 64'(io_resp_valid), 64'd0);
      chk("post_rst_busy",     64'(io_busy),       64'd0);
    end
    @(posedge clock); #1;
    io_req_valid = 4'b1111;
    @(negedge clock);
    chk("post_rst_first_grant", 64'(io_req_ready), 64'(4'b0001));
    @(posedge clock); #1;
    io_req_valid = '0;
    repeat (6) @(posedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
